// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the systolic array operand feeder:
//   feeder_state_t  - feeder FSM state encoding (IDLE, CLEAR, FEED, DRAIN)
//   DEF_IN_WIDTH    - default operand element width
//   DEF_OUT_WIDTH   - default accumulator width of the array being fed
//   cnt_width()     - width of the feeder cycle counter for a given SIZE
// -----------------------------------------------------------------------------
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    FEED  = 2'd2,
    DRAIN = 2'd3
  } feeder_state_t;

  localparam int DEF_IN_WIDTH  = 8;
  localparam int DEF_OUT_WIDTH = 2 * DEF_IN_WIDTH + 8;

  // The counter must hold up to 2*SIZE-2 (last FEED step) without wrapping.
  function automatic int cnt_width(input int size);
    return $clog2(2 * size);
  endfunction

endpackage

// File: rtl/feeder_skew.sv
// -----------------------------------------------------------------------------
// feeder_skew
// Combinational skew selector for one operand lane. Lane IDX is valid for
// feed steps IDX .. IDX+SIZE-1 and then presents element (t - IDX) of its
// row/column vector; outside that window it outputs zero and invalid.
// Ports:
//   i_vec   [SIZE] x IN_WIDTH  latched row (A lanes) or column (B lanes)
//   i_t     CNT_W              feed step this lane value is meant for
//   i_en    1                  high when that step is a FEED step
//   o_data  IN_WIDTH           selected element, zero when not valid
//   o_valid 1                  lane qualifier
// -----------------------------------------------------------------------------
module feeder_skew
  import systolic_pkg::*;
#(
  parameter int SIZE     = 3,
  parameter int IN_WIDTH = DEF_IN_WIDTH,
  parameter int IDX      = 0,
  parameter int CNT_W    = cnt_width(SIZE)
) (
  input  logic [IN_WIDTH-1:0] i_vec [SIZE],
  input  logic [CNT_W-1:0]    i_t,
  input  logic                i_en,
  output logic [IN_WIDTH-1:0] o_data,
  output logic                o_valid
);

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment; a path that leaves one unassigned infers a latch.
  always_comb begin
    o_data  = '0;
    o_valid = 1'b0;
    // Comparing against each legal step avoids indexing i_vec with a counter
    // that is wider than the element index.
    for (int k = 0; k < SIZE; k++) begin
      if (i_en && (int'(i_t) == IDX + k)) begin
        o_data  = i_vec[k];
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// -----------------------------------------------------------------------------
// systolic_feeder
// Latches a SIZE x SIZE operand pair on start and streams it into an
// output-stationary systolic array with the diagonal skew that array needs:
// lane i carries A[i][t-i] / B[t-i][i] during feed step t. A one-cycle
// active-low array_reset precedes each job, and SIZE-1 drain cycles follow
// the feed so the last partial products reach the far corner before done.
//
// Build option: define SYSTOLIC_FEEDER_TRANSPOSE_B_EN when b_mat is supplied
// already transposed; lane i then streams b_mat[i][t-i].
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   start        job request, honoured only while ready
//   a_mat/b_mat  [SIZE][SIZE] x IN_WIDTH operand matrices, [row][col]
//   ready        idle and able to accept start
//   busy         job in FEED or DRAIN
//   done         one-cycle pulse on the first IDLE cycle after a job
//   array_reset  active-low array clear, low for the CLEAR cycle
//   a_in/b_in    [SIZE] x IN_WIDTH registered, skewed operand lanes
//   valid_a/b    [SIZE] lane qualifiers
// -----------------------------------------------------------------------------
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int SIZE     = 3,
  parameter int IN_WIDTH = DEF_IN_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [IN_WIDTH-1:0] a_mat [SIZE][SIZE],
  input  logic [IN_WIDTH-1:0] b_mat [SIZE][SIZE],
  output logic                ready,
  output logic                busy,
  output logic                done,
  output logic                array_reset,
  output logic [IN_WIDTH-1:0] a_in  [SIZE],
  output logic [IN_WIDTH-1:0] b_in  [SIZE],
  output logic [SIZE-1:0]     valid_a,
  output logic [SIZE-1:0]     valid_b
);

  localparam int               CNT_W      = cnt_width(SIZE);
  localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(2 * SIZE - 2);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'((SIZE > 1) ? SIZE - 2 : 0);

  feeder_state_t       r_state;
  feeder_state_t       w_state_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_next;
  logic                r_done;
  logic                w_done_next;
  logic                r_array_reset;
  logic                w_accept;
  logic                w_feed_next;

  logic [IN_WIDTH-1:0] r_a_mat [SIZE][SIZE];
  logic [IN_WIDTH-1:0] r_b_mat [SIZE][SIZE];

  logic [IN_WIDTH-1:0] w_a_lane  [SIZE];
  logic [IN_WIDTH-1:0] w_b_lane  [SIZE];
  logic [SIZE-1:0]     w_valid_a;
  logic [SIZE-1:0]     w_valid_b;
  logic [IN_WIDTH-1:0] r_a_in    [SIZE];
  logic [IN_WIDTH-1:0] r_b_in    [SIZE];
  logic [SIZE-1:0]     r_valid_a;
  logic [SIZE-1:0]     r_valid_b;

  assign w_accept    = (r_state == IDLE) && start;
  assign w_feed_next = (w_state_next == FEED);

  // ---------------------------------------------------------------------------
  // FSM: state register and next-state / counter logic
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = '0;
    w_done_next  = 1'b0;
    unique case (r_state)
      IDLE:  if (start) w_state_next = CLEAR;
      CLEAR: w_state_next = FEED;
      FEED: begin
        if (r_cnt == FEED_LAST) begin
          if (SIZE > 1) begin
            w_state_next = DRAIN;
          end else begin
            w_state_next = IDLE;
            w_done_next  = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (r_cnt == DRAIN_LAST) begin
          w_state_next = IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
    // The counter restarts on every state entry and only advances while
    // stepping through FEED or DRAIN.
    if ((w_state_next == r_state) && ((r_state == FEED) || (r_state == DRAIN))) begin
      w_cnt_next = r_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Operand capture: inputs are sampled only on acceptance
  // ---------------------------------------------------------------------------
  // NOTE: the operand store is reset on purpose so that an aborted job leaves
  // no stale data behind; plain storage arrays usually need no reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a_mat <= '{default: '0};
      r_b_mat <= '{default: '0};
    end else if (w_accept) begin
      r_a_mat <= a_mat;
      r_b_mat <= b_mat;
    end
  end

  // ---------------------------------------------------------------------------
  // Lane skew. Selection uses the next state/counter so the registered lanes
  // line up with the FSM step that is current when they are visible.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < SIZE; gi++) begin : g_lane
    logic [IN_WIDTH-1:0] w_a_row [SIZE];
    logic [IN_WIDTH-1:0] w_b_col [SIZE];

    always_comb begin
      for (int k = 0; k < SIZE; k++) begin
        w_a_row[k] = r_a_mat[gi][k];
`ifdef SYSTOLIC_FEEDER_TRANSPOSE_B_EN
        w_b_col[k] = r_b_mat[gi][k];
`else
        w_b_col[k] = r_b_mat[k][gi];
`endif
      end
    end

    feeder_skew #(
      .SIZE     (SIZE),
      .IN_WIDTH (IN_WIDTH),
      .IDX      (gi),
      .CNT_W    (CNT_W)
    ) u_skew_a (
      .i_vec   (w_a_row),
      .i_t     (w_cnt_next),
      .i_en    (w_feed_next),
      .o_data  (w_a_lane[gi]),
      .o_valid (w_valid_a[gi])
    );

    feeder_skew #(
      .SIZE     (SIZE),
      .IN_WIDTH (IN_WIDTH),
      .IDX      (gi),
      .CNT_W    (CNT_W)
    ) u_skew_b (
      .i_vec   (w_b_col),
      .i_t     (w_cnt_next),
      .i_en    (w_feed_next),
      .o_data  (w_b_lane[gi]),
      .o_valid (w_valid_b[gi])
    );
  end

  // ---------------------------------------------------------------------------
  // Registered outputs to the array
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a_in        <= '{default: '0};
      r_b_in        <= '{default: '0};
      r_valid_a     <= '0;
      r_valid_b     <= '0;
      r_done        <= 1'b0;
      r_array_reset <= 1'b0;  // array held in clear while the feeder is
    end else begin
      r_a_in        <= w_a_lane;
      r_b_in        <= w_b_lane;
      r_valid_a     <= w_valid_a;
      r_valid_b     <= w_valid_b;
      r_done        <= w_done_next;
      r_array_reset <= (w_state_next != CLEAR);
    end
  end

  assign ready       = (r_state == IDLE);
  assign busy        = (r_state == FEED) || (r_state == DRAIN);
  assign done        = r_done;
  assign array_reset = r_array_reset;
  assign a_in        = r_a_in;
  assign b_in        = r_b_in;
  assign valid_a     = r_valid_a;
  assign valid_b     = r_valid_b;

endmodule

// File: tb/tb_systolic_feeder.sv
// -----------------------------------------------------------------------------
// tb_systolic_feeder
// Drives systolic_feeder (SIZE=3) into a small output-stationary systolic
// array model. Expected lane vectors are queued when a job is started and
// popped as the DUT presents each FEED step; the array model's result is
// compared with a product computed from the matrices at start time.
// -----------------------------------------------------------------------------
module tb_systolic_feeder;
  import systolic_pkg::*;

  localparam int S = 3;
  localparam int W = 8;

  typedef struct packed {
    logic [S-1:0][W-1:0] a;
    logic [S-1:0][W-1:0] b;
    logic [S-1:0]        va;
    logic [S-1:0]        vb;
  } lane_t;

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a_mat [S][S];
  logic [W-1:0] b_mat [S][S];
  logic         ready, busy, done, array_reset;
  logic [W-1:0] a_in [S];
  logic [W-1:0] b_in [S];
  logic [S-1:0] valid_a, valid_b;

  int    n_checks   = 0;
  int    n_fail     = 0;
  int    cyc        = 0;
  int    last_clear = 0;
  int    prev_clear = 0;
  lane_t exp_q[$];
  int    exp_c [S][S];

  systolic_feeder #(
    .SIZE     (S),
    .IN_WIDTH (W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .a_mat       (a_mat),
    .b_mat       (b_mat),
    .ready       (ready),
    .busy        (busy),
    .done        (done),
    .array_reset (array_reset),
    .a_in        (a_in),
    .b_in        (b_in),
    .valid_a     (valid_a),
    .valid_b     (valid_b)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Output-stationary array model: A flows right, B flows down.
  // ---------------------------------------------------------------------------
  int           acc [S][S];
  logic [W-1:0] pa  [S][S];
  logic [W-1:0] pb  [S][S];

  function automatic int a_src(input int i, input int j);
    if (j == 0) return int'(a_in[i]);
    else        return int'(pa[i][j-1]);
  endfunction

  function automatic int b_src(input int i, input int j);
    if (i == 0) return int'(b_in[j]);
    else        return int'(pb[i-1][j]);
  endfunction

  always @(posedge clk or negedge array_reset) begin
    if (!array_reset) begin
      for (int i = 0; i < S; i++)
        for (int j = 0; j < S; j++) begin
          acc[i][j] <= 0;
          pa[i][j]  <= '0;
          pb[i][j]  <= '0;
        end
    end else begin
      for (int i = 0; i < S; i++)
        for (int j = 0; j < S; j++) begin
          acc[i][j] <= acc[i][j] + a_src(i, j) * b_src(i, j);
          pa[i][j]  <= W'(a_src(i, j));
          pb[i][j]  <= W'(b_src(i, j));
        end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic lane_t model_lane(input int t);
    lane_t e;
    e = '0;
    for (int i = 0; i < S; i++) begin
      if (t >= i && t <= i + S - 1) begin
        e.va[i] = 1'b1;
        e.vb[i] = 1'b1;
        e.a[i]  = a_mat[i][t-i];
`ifdef SYSTOLIC_FEEDER_TRANSPOSE_B_EN
        e.b[i]  = b_mat[i][t-i];
`else
        e.b[i]  = b_mat[t-i][i];
`endif
      end
    end
    return e;
  endfunction

  // Queue the lane vectors and product of the matrices currently presented.
  task automatic push_job();
    for (int t = 0; t < 2*S-1; t++) exp_q.push_back(model_lane(t));
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++) begin
        exp_c[i][j] = 0;
        for (int k = 0; k < S; k++) begin
`ifdef SYSTOLIC_FEEDER_TRANSPOSE_B_EN
          exp_c[i][j] += int'(a_mat[i][k]) * int'(b_mat[j][k]);
`else
          exp_c[i][j] += int'(a_mat[i][k]) * int'(b_mat[k][j]);
`endif
        end
      end
  endtask

  task automatic random_mats();
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++) begin
        a_mat[i][j] = W'($urandom_range(0, 255));
        b_mat[i][j] = W'($urandom_range(0, 255));
      end
  endtask

  // Runs one job from an IDLE cycle up to and including its done cycle.
  // mode: 0 plain, 1 start pulse at t=1, 2 a_mat changed at t=2,
  //       3 stop after checking t=3 (caller aborts), 4 start held high.
  task automatic drive_job(input string name, input int mode);
    lane_t               e;
    logic [S-1:0][W-1:0] oa, ob;
    push_job();
    start = 1'b1;
    tick();
    if (mode != 4) start = 1'b0;
    prev_clear = last_clear;
    last_clear = cyc;
    n_checks++;
    if (array_reset !== 1'b0 || ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_clear: array_reset=%b ready=%b busy=%b, want 0 0 0",
               name, array_reset, ready, busy);
    end
    for (int t = 0; t < 2*S-1; t++) begin
      tick();
      if (mode != 4) start = 1'b0;
      for (int i = 0; i < S; i++) begin
        oa[i] = a_in[i];
        ob[i] = b_in[i];
      end
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s_feed_t%0d: scoreboard empty", name, t);
      end else begin
        e = exp_q.pop_front();
        if ({oa, ob, valid_a, valid_b} !== e || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL %s_feed_t%0d: a=%h b=%h va=%b vb=%b busy=%b, want a=%h b=%h va=%b vb=%b busy=1",
                   name, t, oa, ob, valid_a, valid_b, busy, e.a, e.b, e.va, e.vb);
        end
      end
      if (mode == 3 && t == 3) return;
      if (mode == 1 && t == 1) start = 1'b1;
      if (mode == 2 && t == 2) begin
        for (int i = 0; i < S; i++)
          for (int j = 0; j < S; j++) a_mat[i][j] = W'(9);
      end
    end
    for (int d = 0; d < S-1; d++) begin
      tick();
      if (mode != 4) start = 1'b0;
      for (int i = 0; i < S; i++) begin
        oa[i] = a_in[i];
        ob[i] = b_in[i];
      end
      n_checks++;
      if (oa !== '0 || ob !== '0 || valid_a !== '0 || valid_b !== '0 ||
          busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_drain%0d: a=%h b=%h va=%b vb=%b busy=%b done=%b, want zeros busy=1 done=0",
                 name, d, oa, ob, valid_a, valid_b, busy, done);
      end
    end
    tick();
    n_checks++;
    if (done !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done: done=%b ready=%b busy=%b, want 1 1 0", name, done, ready, busy);
    end
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++) begin
        n_checks++;
        if (acc[i][j] !== exp_c[i][j]) begin
          n_fail++;
          $display("FAIL %s_out[%0d][%0d]: got %0d, want %0d", name, i, j, acc[i][j], exp_c[i][j]);
        end
      end
  endtask

  // Idle cycles after a done: no further done pulse and no new job.
  task automatic idle_phase(input string name, input int n);
    for (int c = 0; c < n; c++) begin
      tick();
      n_checks++;
      if (done !== 1'b0 || ready !== 1'b1 || array_reset !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_idle%0d: done=%b ready=%b array_reset=%b, want 0 1 1",
                 name, c, done, ready, array_reset);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [S-1:0][W-1:0] oa, ob;
    reset = 1'b0;
    #1;
    for (int i = 0; i < S; i++) begin
      oa[i] = a_in[i];
      ob[i] = b_in[i];
    end
    n_checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || array_reset !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: ready=%b busy=%b done=%b array_reset=%b, want 1 0 0 0",
               ready, busy, done, array_reset);
    end
    n_checks++;
    if (oa !== '0 || ob !== '0 || valid_a !== '0 || valid_b !== '0) begin
      n_fail++;
      $display("FAIL reset_lanes: a=%h b=%h va=%b vb=%b, want all 0", oa, ob, valid_a, valid_b);
    end
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    tick();
    n_checks++;
    if (array_reset !== 1'b1 || ready !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: array_reset=%b ready=%b done=%b, want 1 1 0",
               array_reset, ready, done);
    end
  endtask

  task automatic test_basic();
    int ta [5][3] = '{'{1,0,0}, '{2,4,0}, '{3,5,7}, '{0,6,8}, '{0,0,9}};
    int tb [5][3] = '{'{1,0,0}, '{4,2,0}, '{7,5,3}, '{0,8,6}, '{0,0,9}};
    int tc [3][3] = '{'{30,36,42}, '{66,81,96}, '{102,126,150}};
    lane_t e;
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++) begin
        a_mat[i][j] = W'(i*S + j + 1);
        b_mat[i][j] = W'(i*S + j + 1);
      end
    drive_job("basic", 0);
    // Independent check against the worked example values.
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++) begin
        n_checks++;
        if (acc[i][j] !== tc[i][j]) begin
          n_fail++;
          $display("FAIL basic_ref[%0d][%0d]: got %0d, want %0d", i, j, acc[i][j], tc[i][j]);
        end
      end
    idle_phase("basic", 1);
    // Replay with the literal lane table as the scoreboard contents.
    for (int t = 0; t < 5; t++) begin
      e = '0;
      for (int i = 0; i < S; i++) begin
        e.a[i]  = W'(ta[t][i]);
        e.va[i] = (ta[t][i] != 0);
`ifdef SYSTOLIC_FEEDER_TRANSPOSE_B_EN
        e.b[i]  = model_lane(t).b[i];
`else
        e.b[i]  = W'(tb[t][i]);
`endif
        e.vb[i] = e.va[i];
      end
      exp_q.push_back(e);
    end
    drive_job("basic_tbl", 0);
    // drive_job queued its own model entries behind the table; drop them.
    exp_q.delete();
    idle_phase("basic_tbl", 1);
  endtask

  task automatic test_start_ignored();
    random_mats();
    drive_job("start_ign", 1);
    idle_phase("start_ign", 2*S);
  endtask

  task automatic test_input_change();
    random_mats();
    drive_job("in_change", 2);
    idle_phase("in_change", 1);
  endtask

  task automatic test_reset_abort();
    logic [S-1:0][W-1:0] oa, ob;
    random_mats();
    drive_job("abort", 3);
    reset = 1'b0;
    #1;
    for (int i = 0; i < S; i++) begin
      oa[i] = a_in[i];
      ob[i] = b_in[i];
    end
    n_checks++;
    if (oa !== '0 || ob !== '0 || valid_a !== '0 || valid_b !== '0 ||
        ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_now: a=%h b=%h va=%b vb=%b ready=%b busy=%b done=%b, want zeros 1 0 0",
               oa, ob, valid_a, valid_b, ready, busy, done);
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    idle_phase("abort", 2*S);
    random_mats();
    drive_job("after_abort", 0);
    idle_phase("after_abort", 1);
  endtask

  task automatic test_back_to_back();
    random_mats();
    drive_job("b2b_1", 4);
    random_mats();
    drive_job("b2b_2", 4);
    start = 1'b0;
    n_checks++;
    if (last_clear - prev_clear !== 3*S) begin
      n_fail++;
      $display("FAIL b2b_period: got %0d cycles, want %0d", last_clear - prev_clear, 3*S);
    end
    idle_phase("b2b", 2);
  endtask

  initial begin
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++) begin
        a_mat[i][j] = '0;
        b_mat[i][j] = '0;
      end
    #1;
    test_reset();
    test_basic();
    test_start_ignored();
    test_input_change();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 SHALL have parameter SIZE, default 3, array dimension (rows = cols).
REQ-002 SHALL have parameter IN_WIDTH, default 8, operand element width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request to multiply the presented matrices.
REQ-006 SHALL have port a_mat  input  [SIZE][SIZE] x IN_WIDTH  matrix A, a_mat[row][col].
REQ-007 SHALL have port b_mat  input  [SIZE][SIZE] x IN_WIDTH  matrix B, b_mat[row][col].
REQ-008 SHALL have port ready  output  1  high when idle and able to accept start.
REQ-009 SHALL have port busy  output  1  high while a job is in FEED or DRAIN.
REQ-010 SHALL have port done  output  1  one-cycle pulse; array outputs hold the final product.
REQ-011 SHALL have port array_reset  output  1  active-low clear for the array, low one cycle per job.
REQ-012 SHALL have ports a_in, b_in  output  [SIZE] x IN_WIDTH  skewed operand lanes to the array.
REQ-013 SHALL have ports valid_a, valid_b  output  [SIZE] x 1  per-lane qualifiers.

Function
REQ-014 SHALL implement FSM states IDLE, CLEAR, FEED, DRAIN.
REQ-015 In IDLE, start=1 SHALL latch a_mat/b_mat into internal registers and go to CLEAR; inputs SHALL be ignored afterwards until the next accept.
REQ-016 CLEAR SHALL last exactly one cycle, drive array_reset=0, all lanes invalid, then enter FEED with t=0.
REQ-017 FEED SHALL last 2*SIZE-1 cycles, t = 0..2*SIZE-2.
REQ-018 In FEED, lane i SHALL be valid iff i <= t <= i+SIZE-1, with a_in[i]=A[i][t-i] and b_in[i]=B[t-i][i].
REQ-019 Invalid lanes SHALL drive data 0 and valid 0.
REQ-020 DRAIN SHALL last SIZE-1 cycles with all lanes invalid and zero; SIZE=1 SHALL skip DRAIN.
REQ-021 After DRAIN, the FSM SHALL return to IDLE and assert done for exactly the first IDLE cycle.
REQ-022 start in the same cycle as done SHALL be accepted as a new job.
REQ-023 ready SHALL equal (state==IDLE); busy SHALL equal (state==FEED or DRAIN).
REQ-024 start while not in IDLE SHALL be ignored with no queuing.
REQ-025 The cycle counter SHALL be $clog2(2*SIZE) bits wide, SHALL clear on each state entry, and SHALL never wrap inside a state.
REQ-026 All lane outputs SHALL be registered, so that array inputs change only on clk edges.

Reset
REQ-027 reset=0 SHALL asynchronously force IDLE, counter 0, all latched matrices 0, and lanes 0/invalid.
REQ-028 During reset, outputs SHALL be ready=1, busy=0, done=0, array_reset=0; array_reset SHALL return to 1 on the first clock after release.
REQ-029 reset asserted mid-FEED/DRAIN SHALL abort the job with no done pulse.

Configuration
REQ-030 SYSTOLIC_FEEDER_TRANSPOSE_B_EN defined: b_mat SHALL be taken as B transposed, with b_in[i]=b_mat[i][t-i].
REQ-031 When SYSTOLIC_FEEDER_TRANSPOSE_B_EN is undefined, REQ-018 indexing SHALL apply; A handling SHALL be unchanged in both cases.

Structure
REQ-032 The shared package systolic_pkg SHALL hold the feeder_state_t enum and default IN_WIDTH/OUT_WIDTH constants.
REQ-033 Sub-module feeder_skew SHALL compute one lane's (data, valid) from the latched row/column and t, instantiated 2*SIZE times.

Verification
REQ-034 SIZE=3, A=B=[[1,2,3],[4,5,6],[7,8,9]], start pulse: the bench SHALL check the following.
  - The cycle after acceptance SHALL have array_reset=0.
  - FEED t=0: a_in={1,0,0}, b_in={1,0,0}.
  - t=1: a_in={2,4,0}, b_in={4,2,0}.
  - t=2: a_in={3,5,7}, b_in={7,5,3}.
  - t=3: a_in={0,6,8}, b_in={0,8,6}.
  - t=4: a_in={0,0,9}, b_in={0,0,9}.
  - Then 2 DRAIN cycles, then done.
REQ-035 The same job SHALL drive a systolic instance; at done its out SHALL equal [[30,36,42],[66,81,96],[102,126,150]].
REQ-036 start pulsed at t=1 of FEED SHALL be ignored: the lane sequence SHALL be unchanged and there SHALL be exactly one done.
REQ-037 Changing a_mat to all 9s at t=2 SHALL leave the streamed values equal to the latched originals.
REQ-038 reset driven low at t=3 SHALL immediately zero lanes, set ready=1, and produce no done; a new job SHALL then complete normally.
REQ-039 start held high continuously SHALL produce back-to-back jobs with done and CLEAR in adjacent cycles and period 3*SIZE cycles (SIZE=3: 9).
